// File: rtl/alu_sched_pkg.sv
// Shared types and op-field layout for the ALU scheduler.
// Op word layout: {sel[2:0], A_L, L_R, S_U, Add_Sub}.
package alu_sched_pkg;

    localparam int OP_W       = 7;
    localparam int OP_SEL_LSB = 4;
    localparam int OP_SEL_W   = 3;
    localparam int OP_AL      = 3;
    localparam int OP_LR      = 2;
    localparam int OP_SU      = 1;
    localparam int OP_AS      = 0;

    typedef enum logic {
        PORT_EXU = 1'b0,
        PORT_BRU = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [OP_SEL_W-1:0] sel;
        logic                a_l;
        logic                l_r;
        logic                s_u;
        logic                add_sub;
    } alu_ctrl_t;

    function automatic alu_ctrl_t op_decode(input logic [OP_W-1:0] op);
        alu_ctrl_t c;
        c.sel     = op[OP_SEL_LSB +: OP_SEL_W];
        c.a_l     = op[OP_AL];
        c.l_r     = op[OP_LR];
        c.s_u     = op[OP_SU];
        c.add_sub = op[OP_AS];
        return c;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response handshake bundle between the issue logic and alu_sched.
interface alu_sched_if
    import alu_sched_pkg::*;
#(
    parameter int W = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OP_W-1:0] req0_op;
    logic [W-1:0]    req0_a;
    logic [W-1:0]    req0_b;
    logic            req1_valid;
    logic            req1_ready;
    logic [OP_W-1:0] req1_op;
    logic [W-1:0]    req1_a;
    logic [W-1:0]    req1_b;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [W-1:0]    rsp0_result;
    logic            rsp0_less;
    logic            rsp0_zero;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [W-1:0]    rsp1_result;
    logic            rsp1_less;
    logic            rsp1_zero;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_less, rsp0_zero,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_less, rsp1_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_less, rsp0_zero,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_less, rsp1_zero
    );
endinterface

// File: rtl/alu_rr_arb.sv
// Two-way arbiter for the shared ALU. Round-robin by default;
// defining ALU_SCHED_FIXED_PRIO_EN makes port 0 win every tie.
module alu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_eligible,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

`ifdef ALU_SCHED_FIXED_PRIO_EN
    logic w_unused_rr;
    assign w_unused_rr = ^{clk, rst_n, i_accept};

    // Tie always resolves to port 0.
    always_comb begin
        o_grant = 2'b00;
        if (i_eligible == 2'b11) begin
            o_grant = 2'b01;
        end else begin
            o_grant = i_eligible;
        end
    end
`else
    logic r_last_grant;

    // Remember which port won the most recent accept; port 1 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_grant[1];
        end
    end

    // Tie goes to the port that did not win last time.
    always_comb begin
        o_grant = 2'b00;
        if (i_eligible == 2'b11) begin
            o_grant = r_last_grant ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_eligible;
        end
    end
`endif

endmodule

// File: rtl/alu_sched.sv
// Two-port scheduler sharing one combinational ALU: arbitrate, issue, capture.
// Tie policy selectable with ALU_SCHED_FIXED_PRIO_EN (see alu_rr_arb).
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_sched_if.slave   bus,
    output logic [2:0]   alu_sel,
    output logic         alu_a_l,
    output logic         alu_l_r,
    output logic         alu_s_u,
    output logic         alu_add_sub,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic         alu_less,
    input  logic         alu_zero
);

    logic [1:0]      w_req_valid;
    logic [1:0]      w_rsp_ready;
    logic [1:0]      w_rsp_fire;
    logic [1:0]      w_eligible;
    logic [1:0]      w_grant;
    logic [1:0]      w_capture;
    logic            w_accept;
    logic [OP_W-1:0] w_op;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;

    logic [1:0]      r_busy;
    logic [1:0]      r_rsp_valid;
    logic [W-1:0]    r_rsp_result [2];
    logic [1:0]      r_rsp_less;
    logic [1:0]      r_rsp_zero;
    logic            r_issue_v;
    port_id_e        r_issue_port;
    alu_ctrl_t       r_issue_ctrl;
    logic [W-1:0]    r_issue_a;
    logic [W-1:0]    r_issue_b;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};
    assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign w_rsp_fire  = r_rsp_valid & w_rsp_ready;
    // A port draining its response this cycle may already be re-accepted.
    assign w_eligible  = w_req_valid & (~r_busy | w_rsp_fire) & {2{rst_n}};
    assign w_accept    = |w_grant;
    assign w_capture   = {r_issue_v & (r_issue_port == PORT_BRU),
                          r_issue_v & (r_issue_port == PORT_EXU)};

    alu_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_eligible (w_eligible),
        .i_accept   (w_accept),
        .o_grant    (w_grant)
    );

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    // Select the granted port's payload for the issue register.
    always_comb begin
        w_op = bus.req0_op;
        w_a  = bus.req0_a;
        w_b  = bus.req0_b;
        if (w_grant[1]) begin
            w_op = bus.req1_op;
            w_a  = bus.req1_a;
            w_b  = bus.req1_b;
        end else begin
            w_op = bus.req0_op;
            w_a  = bus.req0_a;
            w_b  = bus.req0_b;
        end
    end

    // Issue register: loads on accept and otherwise holds so the ALU stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_v    <= 1'b0;
            r_issue_port <= PORT_EXU;
            r_issue_ctrl <= '0;
            r_issue_a    <= '0;
            r_issue_b    <= '0;
        end else begin
            r_issue_v <= w_accept;
            if (w_accept) begin
                r_issue_port <= port_id_e'(w_grant[1]);
                r_issue_ctrl <= op_decode(w_op);
                r_issue_a    <= w_a;
                r_issue_b    <= w_b;
            end
        end
    end

    // Per-port busy and response buffers; a new accept wins over a same-edge fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_less  <= 2'b00;
            r_rsp_zero  <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_rsp_result[n] <= '0;
            end
        end else begin
            r_busy      <= (r_busy & ~w_rsp_fire) | w_grant;
            r_rsp_valid <= (r_rsp_valid & ~w_rsp_fire) | w_capture;
            for (int n = 0; n < 2; n++) begin
                if (w_capture[n]) begin
                    r_rsp_result[n] <= alu_result;
                    r_rsp_less[n]   <= alu_less;
                    r_rsp_zero[n]   <= alu_zero;
                end
            end
        end
    end

    assign bus.rsp0_valid  = r_rsp_valid[0];
    assign bus.rsp0_result = r_rsp_result[0];
    assign bus.rsp0_less   = r_rsp_less[0];
    assign bus.rsp0_zero   = r_rsp_zero[0];
    assign bus.rsp1_valid  = r_rsp_valid[1];
    assign bus.rsp1_result = r_rsp_result[1];
    assign bus.rsp1_less   = r_rsp_less[1];
    assign bus.rsp1_zero   = r_rsp_zero[1];

    assign alu_sel     = r_issue_ctrl.sel;
    assign alu_a_l     = r_issue_ctrl.a_l;
    assign alu_l_r     = r_issue_ctrl.l_r;
    assign alu_s_u     = r_issue_ctrl.s_u;
    assign alu_add_sub = r_issue_ctrl.add_sub;
    assign alu_a       = r_issue_a;
    assign alu_b       = r_issue_b;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small reference ALU closing the loop.
module tb_alu_sched;

    logic        clk;
    logic        rst_n;
    logic [2:0]  alu_sel;
    logic        alu_a_l, alu_l_r, alu_s_u, alu_add_sub;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_less, alu_zero;

    int total = 0;
    int bad   = 0;

    alu_sched_if #(.W(32)) bus ();

    alu_sched #(.W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_sel     (alu_sel),
        .alu_a_l     (alu_a_l),
        .alu_l_r     (alu_l_r),
        .alu_s_u     (alu_s_u),
        .alu_add_sub (alu_add_sub),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_less    (alu_less),
        .alu_zero    (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 0 add/sub, 1 slt, 2 and, 3 or, 4 xor, 5 shift, 6 pass a, 7 pass b.
    always_comb begin
        if (alu_s_u) alu_less = (alu_a < alu_b);
        else         alu_less = ($signed(alu_a) < $signed(alu_b));
        alu_result = 32'd0;
        case (alu_sel)
            3'd0: alu_result = alu_add_sub ? (alu_a - alu_b) : (alu_a + alu_b);
            3'd1: alu_result = {31'd0, alu_less};
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: begin
                if (!alu_l_r)     alu_result = alu_a << alu_b[4:0];
                else if (alu_a_l) alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
                else              alu_result = alu_a >> alu_b[4:0];
            end
            3'd6: alu_result = alu_a;
            default: alu_result = alu_b;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    function automatic logic [6:0] mkop(input logic [2:0] sel, input logic al,
                                        input logic lr, input logic su, input logic as_);
        return {sel, al, lr, su, as_};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    endtask

    task automatic drv1(input logic v, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    endtask

    task automatic do_reset();
        drv0(1'b0, 7'd0, 32'd0, 32'd0);
        drv1(1'b0, 7'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Streaming vectors: port 0 (EXU) and port 1 (BRU), hand-computed results.
    logic [6:0]  s_op0 [5], s_op1 [5];
    logic [31:0] s_a0 [5], s_b0 [5], s_e0 [5];
    logic [31:0] s_a1 [5], s_b1 [5], s_e1 [5];

    initial begin
        int i0, i1, r0, r1, n_acc1;
        logic g0, g1;

        s_op0[0] = mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0); s_a0[0] = 32'd100;        s_b0[0] = 32'd23; s_e0[0] = 32'd123;
        s_op0[1] = mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b1); s_a0[1] = 32'd10;         s_b0[1] = 32'd20; s_e0[1] = 32'hFFFF_FFF6;
        s_op0[2] = mkop(3'd1, 1'b0, 1'b0, 1'b0, 1'b0); s_a0[2] = 32'hFFFF_FFFF;  s_b0[2] = 32'd1;  s_e0[2] = 32'd1;
        s_op0[3] = mkop(3'd1, 1'b0, 1'b0, 1'b1, 1'b0); s_a0[3] = 32'hFFFF_FFFF;  s_b0[3] = 32'd1;  s_e0[3] = 32'd0;
        s_op0[4] = mkop(3'd5, 1'b0, 1'b0, 1'b0, 1'b0); s_a0[4] = 32'd1;          s_b0[4] = 32'd4;  s_e0[4] = 32'd16;
        s_op1[0] = mkop(3'd1, 1'b0, 1'b0, 1'b0, 1'b0); s_a1[0] = 32'd5;          s_b1[0] = 32'd5;  s_e1[0] = 32'd0;
        s_op1[1] = mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b1); s_a1[1] = 32'd7;          s_b1[1] = 32'd7;  s_e1[1] = 32'd0;
        s_op1[2] = mkop(3'd5, 1'b1, 1'b1, 1'b0, 1'b0); s_a1[2] = 32'h8000_0000;  s_b1[2] = 32'd4;  s_e1[2] = 32'hF800_0000;
        s_op1[3] = mkop(3'd5, 1'b0, 1'b1, 1'b0, 1'b0); s_a1[3] = 32'h8000_0000;  s_b1[3] = 32'd4;  s_e1[3] = 32'h0800_0000;
        s_op1[4] = mkop(3'd7, 1'b0, 1'b0, 1'b0, 1'b0); s_a1[4] = 32'd0;          s_b1[4] = 32'hDEAD_BEEF; s_e1[4] = 32'hDEAD_BEEF;

        // Reset state, with requests already valid.
        rst_n = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        drv0(1'b1, 7'd0, 32'd0, 32'd0);
        drv1(1'b1, 7'd0, 32'd0, 32'd0);
        tick();
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        chk("rst_rsp0_result", bus.rsp0_result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", {25'd0, alu_sel, alu_a_l, alu_l_r, alu_s_u, alu_add_sub}, 32'd0);
        do_reset();

        // Single op: 5 + 3 on port 0.
        drv0(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd5, 32'd3);
        #1;
        chk("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("single_ready1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd3);
        chk("single_rsp0_early", {31'd0, bus.rsp0_valid}, 32'd0);
        tick();
        chk("single_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("single_rsp0_result", bus.rsp0_result, 32'd8);
        chk("single_rsp0_zero", {31'd0, bus.rsp0_zero}, 32'd0);
        chk("single_rsp1_idle", {31'd0, bus.rsp1_valid}, 32'd0);
        bus.rsp0_ready = 1'b1;
        tick();
        chk("single_rsp0_drained", {31'd0, bus.rsp0_valid}, 32'd0);

        // Tie after reset: port 0 first, port 1 next cycle.
        do_reset();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drv0(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd1, 32'd1);
        drv1(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b1), 32'd3, 32'd3);
        #1;
        chk("tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("tie_ready1_low", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("tie_ready1", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("tie_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("tie_rsp0_result", bus.rsp0_result, 32'd2);
        chk("tie_alu_sub", {31'd0, alu_add_sub}, 32'd1);
        tick();
        chk("tie_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        chk("tie_rsp1_result", bus.rsp1_result, 32'd0);
        chk("tie_rsp1_zero", {31'd0, bus.rsp1_zero}, 32'd1);
        chk("tie_rsp0_drained", {31'd0, bus.rsp0_valid}, 32'd0);
        tick();

        // Backpressure on port 0 while port 1 keeps flowing.
        bus.rsp0_ready = 1'b0;
        drv0(1'b1, mkop(3'd2, 1'b0, 1'b0, 1'b0, 1'b0), 32'h0000_F0F0, 32'h0000_0FF0);
        #1;
        tick();
        drv0(1'b1, mkop(3'd3, 1'b0, 1'b0, 1'b0, 1'b0), 32'd1, 32'd2);
        tick();
        chk("bp_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("bp_rsp0_result", bus.rsp0_result, 32'h0000_00F0);
        drv1(1'b1, mkop(3'd4, 1'b0, 1'b0, 1'b0, 1'b0), 32'h10, 32'h01);
        n_acc1 = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready0_low", {31'd0, bus.req0_ready}, 32'd0);
            chk("bp_rsp0_hold", bus.rsp0_result, 32'h0000_00F0);
            if (bus.req1_ready) n_acc1++;
            tick();
        end
        bus.req1_valid = 1'b0;
        chk("bp_port1_accepts", n_acc1, 32'd3);
        bus.rsp0_ready = 1'b1;
        #1;
        chk("bp_release_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("bp_rsp0_fired", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("bp_rsp1_result", bus.rsp1_result, 32'h11);
        chk("bp_next_alu_a", alu_a, 32'd1);
        tick();
        chk("bp_rsp0_next", bus.rsp0_result, 32'd3);
        tick();

        // Streaming, alternating ports, all consumers ready.
        do_reset();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        i0 = 0; i1 = 0; r0 = 0; r1 = 0;
        for (int cyc = 0; cyc < 40 && !(r0 == 5 && r1 == 5); cyc++) begin
            if (i0 < 5) drv0(1'b1, s_op0[i0], s_a0[i0], s_b0[i0]);
            else        drv0(1'b0, 7'd0, 32'd0, 32'd0);
            if (i1 < 5) drv1(1'b1, s_op1[i1], s_a1[i1], s_b1[i1]);
            else        drv1(1'b0, 7'd0, 32'd0, 32'd0);
            #1;
            g0 = bus.req0_ready;
            g1 = bus.req1_ready;
            if (i0 < 5 && i1 < 5) chk("stream_one_grant", {31'd0, g0 ^ g1}, 32'd1);
            if (bus.rsp0_valid && r0 < 5) begin
                chk("stream_rsp0", bus.rsp0_result, s_e0[r0]);
                chk("stream_zero0", {31'd0, bus.rsp0_zero}, {31'd0, s_e0[r0] == 32'd0});
                r0++;
            end
            if (bus.rsp1_valid && r1 < 5) begin
                chk("stream_rsp1", bus.rsp1_result, s_e1[r1]);
                chk("stream_zero1", {31'd0, bus.rsp1_zero}, {31'd0, s_e1[r1] == 32'd0});
                r1++;
            end
            tick();
            if (g0) i0++;
            if (g1) i1++;
        end
        chk("stream_count0", r0, 32'd5);
        chk("stream_count1", r1, 32'd5);

        // Reset in the cycle after an accept discards the op.
        do_reset();
        bus.rsp0_ready = 1'b1;
        drv0(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd1, 32'd2);
        #1;
        tick();
        bus.req0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("midrst_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
            tick();
        end
        drv0(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd0, 32'd0);
        #1;
        chk("midrst_not_busy", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();

        // Tie with port 0 as the last winner: tie policy decides.
        do_reset();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        drv1(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd7, 32'd0);
        #1;
        tick();
        bus.req1_valid = 1'b0;
        drv0(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd9, 32'd0);
        #1;
        chk("prio_ready0_first", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("prio_both_full", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd3);
        drv0(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd2, 32'd2);
        drv1(1'b1, mkop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd4, 32'd4);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        chk("prio_tie_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("prio_loser_next", {31'd0, bus.req1_ready}, 32'd1);
`else
        chk("prio_tie_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("prio_loser_next", {31'd0, bus.req0_ready}, 32'd1);
`endif
        tick();
        drv0(1'b0, 7'd0, 32'd0, 32'd0);
        drv1(1'b0, 7'd0, 32'd0, 32'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
